// File: rtl/rr_select_arbiter24.sv
// rr_select_arbiter24: round-robin arbiter in front of a 5-to-24 select decoder.
// Emits a binary grant index + enable (decoder input format) and a registered
// one-hot grant. A grant is held until done, request withdrawal, or (with
// ARB_TIMEOUT_EN defined) a forced release after MAX_HOLD cycles.
// Optional feature macro: ARB_TIMEOUT_EN.

// Per-requester cell: flags a request that sits at or above the priority pointer.
module rr_select_arbiter24_lane #(
  parameter int IDX   = 0,
  parameter int IDX_W = 5
) (
  input  logic             req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hi
);
  assign hi = req && (IDX_W'(IDX) >= ptr);
endmodule

module rr_select_arbiter24 #(
  parameter int N_REQ    = 24,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_en,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             timeout
);

  // Elaboration-time guard on illegal configurations.
  if (N_REQ < 2 || N_REQ > 32 || (2 ** IDX_W) < N_REQ || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_select_arbiter24: illegal parameter combination");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N_REQ-1:0] ONE  = N_REQ'(1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] hi_req;
  logic [IDX_W-1:0] win_lo, win_hi, win_idx;
  logic             any_hi;
  logic             req_any;
  logic             owner_req;
  logic             expire;
  logic             release_now;

  // Split requests into "at or after ptr" so the circular search becomes two linear ones.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    rr_select_arbiter24_lane #(.IDX(i), .IDX_W(IDX_W)) u_lane (
      .req (req[i]),
      .ptr (ptr),
      .hi  (hi_req[i])
    );
  end

  // Lowest set bit at/after ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    win_lo = '0;
    win_hi = '0;
    any_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_lo = IDX_W'(i);
      if (hi_req[i]) begin
        win_hi = IDX_W'(i);
        any_hi = 1'b1;
      end
    end
    win_idx = any_hi ? win_hi : win_lo;
  end

  assign req_any   = |req;
  assign owner_req = req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              force_rel;

  // Counts completed GRANT cycles; cleared whenever idle so each grant starts at zero.
  always_ff @(posedge clk) begin
    if (rst)                hold_cnt <= '0;
    else if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
    else                    hold_cnt <= '0;
  end

  // Expiry in the last allowed GRANT cycle; done takes precedence and suppresses the pulse.
  assign expire    = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign force_rel = expire && !done && owner_req;

  // One-cycle pulse in the cycle after a forced release edge.
  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= release_now && force_rel;
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // All release causes collapse into one event.
  assign release_now = (state == GRANT) && (done || !owner_req || expire);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: arbitrate from IDLE, return to IDLE on any release.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any)     state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Grant outputs and priority pointer; idx is frozen while granted and held after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_idx    <= '0;
      gnt_en     <= 1'b0;
      gnt_onehot <= '0;
      ptr        <= '0;
    end else if (state == IDLE && req_any) begin
      gnt_idx    <= win_idx;
      gnt_en     <= 1'b1;
      gnt_onehot <= ONE << win_idx;
    end else if (release_now) begin
      gnt_en     <= 1'b0;
      gnt_onehot <= '0;
      ptr        <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule
